// File: rtl/minim_serial.sv
// -----------------------------------------------------------------------------
// minim_serial
//
// Streaming per-frame minimum finder. Unsigned WIDTH-bit samples arrive one per
// cycle over a valid/ready handshake and are grouped into frames of N samples.
// When a frame completes, the block presents the frame's minimum value and the
// position of that minimum, then holds the result until the consumer takes it.
// The earliest position wins when several samples share the minimum value.
//
// Ports:
//   clk        in   rising-edge clock for all logic
//   rst        in   synchronous, active-high reset
//   in_valid   in   producer has a sample on in_data
//   in_ready   out  block accepts a sample this cycle (state COLLECT)
//   in_data    in   WIDTH-bit unsigned sample
//   out_valid  out  out_min/out_idx hold a completed frame result (state HOLD)
//   out_ready  in   consumer takes the result this cycle
//   out_min    out  minimum sample of the last completed frame
//   out_idx    out  position (0..N-1) of that minimum within its frame
// -----------------------------------------------------------------------------
module minim_serial #(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int IDXW  = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_min,
  output logic [IDXW-1:0]  out_idx
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  state_e           state_q;
  logic [IDXW-1:0]  cnt_q;
  logic [WIDTH-1:0] run_min_q;
  logic [WIDTH-1:0] run_min_d;
  logic [IDXW-1:0]  run_idx_q;
  logic [IDXW-1:0]  run_idx_d;
  logic [WIDTH-1:0] out_min_q;
  logic [IDXW-1:0]  out_idx_q;

  logic accept;
  logic first;
  logic lower;

  // Handshake flags decode straight from the state register, so neither side
  // sees a combinational path from the other side's inputs.
  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == HOLD);

  assign accept = in_valid && in_ready;
  assign first  = (cnt_q == '0);
  // Strict compare keeps the earliest index on ties.
  assign lower  = (in_data < run_min_q);

  // Running minimum including the sample offered this cycle. The first sample
  // of a frame seeds the running values regardless of what they held before.
  always_comb begin
    run_min_d = run_min_q;
    run_idx_d = run_idx_q;
    if (first) begin
      run_min_d = in_data;
      run_idx_d = '0;
    end else if (lower) begin
      run_min_d = in_data;
      run_idx_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COLLECT;
      cnt_q     <= '0;
      run_min_q <= '0;
      run_idx_q <= '0;
      out_min_q <= '0;
      out_idx_q <= '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (accept) begin
            run_min_q <= run_min_d;
            run_idx_q <= run_idx_d;
            if (cnt_q == LAST_IDX) begin
              // Frame complete: publish the result that includes this sample.
              out_min_q <= run_min_d;
              out_idx_q <= run_idx_d;
              cnt_q     <= '0;
              state_q   <= HOLD;
            end else begin
              cnt_q <= cnt_q + IDXW'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q <= COLLECT;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign out_min = out_min_q;
  assign out_idx = out_idx_q;

endmodule

// File: tb/tb_minim_serial.sv
module tb_minim_serial;

  localparam int WIDTH = 4;
  localparam int N     = 4;
  localparam int IDXW  = 2;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_min;
  logic [IDXW-1:0]  out_idx;

  minim_serial #(.WIDTH(WIDTH), .N(N), .IDXW(IDXW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_min   (out_min),
    .out_idx   (out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [WIDTH-1:0] exp_min;
  logic [IDXW-1:0]  exp_idx;
  logic [WIDTH-1:0] f [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: smallest value in the frame, then the first position holding it.
  task automatic model(input logic [WIDTH-1:0] s [N]);
    int m;
    m = 1 << WIDTH;
    for (int i = 0; i < N; i++) if (int'(s[i]) < m) m = int'(s[i]);
    exp_min = WIDTH'(m);
    exp_idx = '0;
    for (int i = N - 1; i >= 0; i--) if (int'(s[i]) == m) exp_idx = IDXW'(i);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ovalid"}, 32'(out_valid), 32'd0);
    check({tag, "_irdy"},   32'(in_ready),  32'd1);
    check({tag, "_omin"},   32'(out_min),   32'd0);
    check({tag, "_oidx"},   32'(out_idx),   32'd0);
  endtask

  task automatic do_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick;
    rst = 1'b0;
    check_reset_state("rst");
  endtask

  // gmode: 0 no gaps, 1 two idle cycles before sample 2, 2 random gaps.
  task automatic send_frame(input logic [WIDTH-1:0] s [N], input int gmode);
    int g;
    for (int i = 0; i < N; i++) begin
      g = (gmode == 2) ? int'($urandom_range(0, 2)) : ((gmode == 1 && i == 2) ? 2 : 0);
      repeat (g) begin
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom_range(0, 15));
        tick;
        check("gap_ovalid", 32'(out_valid), 32'd0);
        check("gap_irdy",   32'(in_ready),  32'd1);
      end
      in_valid = 1'b1;
      in_data  = s[i];
      tick;
      if (i < N - 1) begin
        check("mid_ovalid", 32'(out_valid), 32'd0);
        check("mid_irdy",   32'(in_ready),  32'd1);
      end
    end
    in_valid = 1'b0;
    model(s);
    check("done_ovalid", 32'(out_valid), 32'd1);
    check("done_irdy",   32'(in_ready),  32'd0);
    check("done_omin",   32'(out_min),   32'(exp_min));
    check("done_oidx",   32'(out_idx),   32'(exp_idx));
  endtask

  // Hold the result for `hold` cycles while offering junk samples, then take it.
  task automatic drain(input int hold);
    repeat (hold) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = WIDTH'($urandom_range(0, 15));
      tick;
      check("bp_ovalid", 32'(out_valid), 32'd1);
      check("bp_irdy",   32'(in_ready),  32'd0);
      check("bp_omin",   32'(out_min),   32'(exp_min));
      check("bp_oidx",   32'(out_idx),   32'(exp_idx));
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = WIDTH'($urandom_range(0, 15));
    tick;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("hs_ovalid", 32'(out_valid), 32'd0);
    check("hs_irdy",   32'(in_ready),  32'd1);
    check("hs_omin",   32'(out_min),   32'(exp_min));
    check("hs_oidx",   32'(out_idx),   32'(exp_idx));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    do_reset;

    f = '{4'd10, 4'd5, 4'd2, 4'd14};  send_frame(f, 0); drain(0);
    f = '{4'd5, 4'd5, 4'd5, 4'd5};    send_frame(f, 0); drain(0);
    f = '{4'd0, 4'd3, 4'd0, 4'd0};    send_frame(f, 0); drain(0);
    f = '{4'd15, 4'd15, 4'd15, 4'd15}; send_frame(f, 0); drain(0);
    f = '{4'd15, 4'd14, 4'd13, 4'd12}; send_frame(f, 0); drain(0);
    f = '{4'd7, 4'd1, 4'd9, 4'd4};    send_frame(f, 0); drain(3);
    f = '{4'd8, 4'd6, 4'd3, 4'd9};    send_frame(f, 1); drain(0);

    // Partial frame thrown away by reset.
    in_valid = 1'b1; in_data = 4'd1; tick;
    in_data = 4'd2; tick;
    in_valid = 1'b0;
    do_reset;
    f = '{4'd9, 4'd8, 4'd7, 4'd6};    send_frame(f, 0); drain(1);

    // Pending result dropped by reset.
    f = '{4'd3, 4'd11, 4'd2, 4'd2};   send_frame(f, 0);
    do_reset;

    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < N; i++)
        f[i] = WIDTH'((k % 2 == 1) ? $urandom_range(0, 3) : $urandom_range(0, 15));
      send_frame(f, 2);
      drain(int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
